// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-to-APB bridge slave port between
// several AHB masters, with a per-owner transfer cap and handover IDLE.
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_HOLD    = 4
) (
    input  logic                      Hclk,
    input  logic                      Hresetn,
    input  logic [NUM_MASTERS-1:0]    Hbusreq,
    input  logic [2*NUM_MASTERS-1:0]  Htrans_m,
    input  logic [32*NUM_MASTERS-1:0] Haddr_m,
    input  logic [NUM_MASTERS-1:0]    Hwrite_m,
    input  logic [3*NUM_MASTERS-1:0]  Hsize_m,
    input  logic [32*NUM_MASTERS-1:0] Hwdata_m,
    input  logic                      Hreadyout,
    output logic [NUM_MASTERS-1:0]    Hgrant,
    output logic [1:0]                Hmaster,
    output logic [1:0]                Htrans,
    output logic [31:0]               Haddr,
    output logic                      Hwrite,
    output logic [2:0]                Hsize,
    output logic [31:0]               Hwdata,
    output logic                      Hreadyin
);

    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1);
    localparam logic [1:0] IDLE = 2'b00;

    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [1:0]             addr_owner_q, addr_owner_d;
    logic [1:0]             data_owner_q, data_owner_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d, hold_next;
    logic [1:0]             trans_sel, grant_idx, winner;
    logic                   owner_granted, owner_req, other_req, rearb;

    // Indices beyond NUM_MASTERS fall back to master 0 via the defaults.
    always_comb begin
        trans_sel     = Htrans_m[1:0];
        Haddr         = Haddr_m[31:0];
        Hwrite        = Hwrite_m[0];
        Hsize         = Hsize_m[2:0];
        owner_granted = hgrant_q[0];
        owner_req     = Hbusreq[0];
        Hwdata        = Hwdata_m[31:0];
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (addr_owner_q == 2'(i)) begin
                trans_sel     = Htrans_m[2*i +: 2];
                Haddr         = Haddr_m[32*i +: 32];
                Hwrite        = Hwrite_m[i];
                Hsize         = Hsize_m[3*i +: 3];
                owner_granted = hgrant_q[i];
                owner_req     = Hbusreq[i];
            end
            if (data_owner_q == 2'(i)) begin
                Hwdata = Hwdata_m[32*i +: 32];
            end
        end
    end

    assign Htrans   = (Hresetn && owner_granted) ? trans_sel : IDLE;
    assign Hgrant   = hgrant_q;
    assign Hmaster  = addr_owner_q;
    assign Hreadyin = Hreadyout;

    always_comb begin
        grant_idx = 2'd0;
        other_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) begin
                grant_idx = 2'(i);
            end
            if (addr_owner_q != 2'(i) && Hbusreq[i]) begin
                other_req = 1'b1;
            end
        end
    end

    // Scan from the far end so the nearest requester after the owner wins.
    always_comb begin
        winner = addr_owner_q;
        for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (((int'(addr_owner_q) + k) % NUM_MASTERS) == i
                    && Hbusreq[i]) begin
                    winner = 2'(i);
                end
            end
        end
    end

    // The cap counts the transfer being accepted this edge, so an owner
    // gets exactly MAX_HOLD transfers before the grant moves on.
    always_comb begin
        hold_next = hold_cnt_q;
        if (Htrans[1] && hold_cnt_q != HOLD_MAX) begin
            hold_next = hold_cnt_q + HW'(1);
        end
        rearb = !owner_req || (hold_next == HOLD_MAX && other_req);
    end

    always_comb begin
        hgrant_d     = hgrant_q;
        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        hold_cnt_d   = hold_cnt_q;
        if (Hreadyout) begin
            if (rearb) begin
                hgrant_d = '0;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (winner == 2'(i)) begin
                        hgrant_d[i] = 1'b1;
                    end
                end
            end
            addr_owner_d = grant_idx;
            data_owner_d = addr_owner_q;
            hold_cnt_d   = (grant_idx != addr_owner_q) ? '0 : hold_next;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hgrant_q     <= GRANT_RST;
            addr_owner_q <= 2'd0;
            data_owner_q <= 2'd0;
            hold_cnt_q   <= '0;
        end else begin
            hgrant_q     <= hgrant_d;
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter with two masters and MAX_HOLD=4.
// Expected values are hand-derived cycle tables; checks are inline per test.
module tb_ahb_bridge_arbiter;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [1:0]  Hbusreq;
    logic [1:0]  tr0, tr1;
    logic [31:0] ad0, ad1, wd0, wd1;
    logic        wr0, wr1;
    logic [2:0]  sz0, sz1;
    logic        Hreadyout;
    logic [1:0]  Hgrant, Hmaster, Htrans;
    logic [31:0] Haddr, Hwdata;
    logic        Hwrite, Hreadyin;
    logic [2:0]  Hsize;

    int checks = 0;
    int errors = 0;

    always #5 Hclk = ~Hclk;

    ahb_bridge_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(4)) dut (
        .Hclk(Hclk),
        .Hresetn(Hresetn),
        .Hbusreq(Hbusreq),
        .Htrans_m({tr1, tr0}),
        .Haddr_m({ad1, ad0}),
        .Hwrite_m({wr1, wr0}),
        .Hsize_m({sz1, sz0}),
        .Hwdata_m({wd1, wd0}),
        .Hreadyout(Hreadyout),
        .Hgrant(Hgrant),
        .Hmaster(Hmaster),
        .Htrans(Htrans),
        .Haddr(Haddr),
        .Hwrite(Hwrite),
        .Hsize(Hsize),
        .Hwdata(Hwdata),
        .Hreadyin(Hreadyin)
    );

    // Leaves reset asserted, 2 ns after a rising edge.
    task automatic do_reset();
        Hresetn = 1'b0;
        @(posedge Hclk); #2;
        @(posedge Hclk); #2;
    endtask

    task automatic next_cycle();
        @(posedge Hclk); #2;
    endtask

    task automatic test_reset();
        Hbusreq = 2'b00; Hreadyout = 1'b1;
        tr0 = 2'b10; tr1 = 2'b00;
        ad0 = 32'h0000_0100; ad1 = 32'h0;
        wd0 = 32'h0; wd1 = 32'h0;
        wr0 = 1'b0; wr1 = 1'b0; sz0 = 3'd2; sz1 = 3'd2;
        do_reset();
        #1;
        checks++;
        if (Htrans !== 2'b00) begin
            errors++;
            $display("FAIL reset_forced_idle got %b exp 00", Htrans);
        end
        checks++;
        if (Hgrant !== 2'b01) begin
            errors++;
            $display("FAIL reset_grant got %b exp 01", Hgrant);
        end
        tr0 = 2'b00;
        Hresetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (Hgrant !== 2'b01) begin
                errors++;
                $display("FAIL rel_grant c%0d got %b exp 01", c, Hgrant);
            end
            checks++;
            if (Hmaster !== 2'd0) begin
                errors++;
                $display("FAIL rel_master c%0d got %0d exp 0", c, Hmaster);
            end
            checks++;
            if (Htrans !== 2'b00) begin
                errors++;
                $display("FAIL rel_trans c%0d got %b exp 00", c, Htrans);
            end
            checks++;
            if (Hreadyin !== 1'b1) begin
                errors++;
                $display("FAIL rel_readyin c%0d got %b exp 1", c, Hreadyin);
            end
            next_cycle();
        end
    endtask

    task automatic test_grant();
        Hbusreq = 2'b10; tr1 = 2'b10; ad1 = 32'h8000_0010;
        #1;
        checks++;
        if (Hgrant !== 2'b01 || Hmaster !== 2'd0) begin
            errors++;
            $display("FAIL grant_pre got %b/%0d exp 01/0", Hgrant, Hmaster);
        end
        next_cycle();
        checks++;
        if (Hgrant !== 2'b10) begin
            errors++;
            $display("FAIL grant_e1 got %b exp 10", Hgrant);
        end
        checks++;
        if (Htrans !== 2'b00 || Hmaster !== 2'd0) begin
            errors++;
            $display("FAIL handover_idle got %b/%0d exp 00/0", Htrans, Hmaster);
        end
        checks++;
        if (Haddr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL handover_addr got %h exp 00000100", Haddr);
        end
        next_cycle();
        checks++;
        if (Hmaster !== 2'd1 || Htrans !== 2'b10) begin
            errors++;
            $display("FAIL m1_owner got %0d/%b exp 1/10", Hmaster, Htrans);
        end
        checks++;
        if (Haddr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL m1_addr got %h exp 80000010", Haddr);
        end
        Hbusreq = 2'b00; tr1 = 2'b00;
        next_cycle();
        next_cycle();
        checks++;
        if (Hgrant !== 2'b10 || Hmaster !== 2'd1) begin
            errors++;
            $display("FAIL park got %b/%0d exp 10/1", Hgrant, Hmaster);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_t;
        logic [1:0] exp_m;
        do_reset();
        Hbusreq = 2'b11; tr0 = 2'b10; tr1 = 2'b10;
        wr0 = 1'b1; wr1 = 1'b1; Hreadyout = 1'b1;
        Hresetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_m = 2'((c / 5) % 2);
            exp_t = (c % 5 == 4) ? 2'b00 : 2'b10;
            checks++;
            if (Hmaster !== exp_m) begin
                errors++;
                $display("FAIL rr_master c%0d got %0d exp %0d", c, Hmaster, exp_m);
            end
            checks++;
            if (Htrans !== exp_t) begin
                errors++;
                $display("FAIL rr_trans c%0d got %b exp %b", c, Htrans, exp_t);
            end
            next_cycle();
        end
    endtask

    task automatic test_handover_wdata();
        do_reset();
        Hbusreq = 2'b10; Hreadyout = 1'b1;
        tr0 = 2'b10; ad0 = 32'h0000_0200; wd0 = 32'hA5A5_0001;
        wr0 = 1'b1; sz0 = 3'b010;
        tr1 = 2'b10; ad1 = 32'h8000_0020; wd1 = 32'hDEAD_BEEF;
        wr1 = 1'b0; sz1 = 3'b001;
        Hresetn = 1'b1;
        #1;
        checks++;
        if (Htrans !== 2'b10 || Haddr !== 32'h0000_0200 || Hwrite !== 1'b1) begin
            errors++;
            $display("FAIL ho_m0_last got %b/%h/%b exp 10/00000200/1",
                     Htrans, Haddr, Hwrite);
        end
        next_cycle();
        tr0 = 2'b00;
        #1;
        checks++;
        if (Htrans !== 2'b00 || Hgrant !== 2'b10) begin
            errors++;
            $display("FAIL ho_idle got %b/%b exp 00/10", Htrans, Hgrant);
        end
        next_cycle();
        checks++;
        if (Hmaster !== 2'd1 || Haddr !== 32'h8000_0020) begin
            errors++;
            $display("FAIL ho_m1_addr got %0d/%h exp 1/80000020", Hmaster, Haddr);
        end
        checks++;
        if (Hwdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL ho_m0_wdata got %h exp a5a50001", Hwdata);
        end
        checks++;
        if (Hwrite !== 1'b0 || Hsize !== 3'b001) begin
            errors++;
            $display("FAIL ho_ctrl got %b/%b exp 0/001", Hwrite, Hsize);
        end
        next_cycle();
        checks++;
        if (Hwdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ho_m1_wdata got %h exp deadbeef", Hwdata);
        end
    endtask

    task automatic test_wait_states();
        logic [16:0] rdy_v  = 17'b11111100110001111;
        logic [16:0] hm_v   = 17'b00111111100000000;
        logic [16:0] idle_v = 17'b00100000011110000;
        logic [16:0] g1_v   = 17'b00011111111110000;
        logic [16:0] wd1_v  = 17'b01111111000000000;
        logic [1:0]  exp_t, exp_g, exp_m;
        logic [31:0] exp_w;
        do_reset();
        Hbusreq = 2'b11; tr0 = 2'b10; tr1 = 2'b10;
        wd0 = 32'h1111_0000; wd1 = 32'h2222_0000;
        Hresetn = 1'b1;
        for (int c = 0; c < 17; c++) begin
            Hreadyout = rdy_v[c];
            #1;
            exp_m = hm_v[c] ? 2'd1 : 2'd0;
            exp_t = idle_v[c] ? 2'b00 : 2'b10;
            exp_g = g1_v[c] ? 2'b10 : 2'b01;
            exp_w = wd1_v[c] ? wd1 : wd0;
            checks++;
            if (Hmaster !== exp_m) begin
                errors++;
                $display("FAIL ws_master c%0d got %0d exp %0d", c, Hmaster, exp_m);
            end
            checks++;
            if (Htrans !== exp_t) begin
                errors++;
                $display("FAIL ws_trans c%0d got %b exp %b", c, Htrans, exp_t);
            end
            checks++;
            if (Hgrant !== exp_g) begin
                errors++;
                $display("FAIL ws_grant c%0d got %b exp %b", c, Hgrant, exp_g);
            end
            checks++;
            if (Hwdata !== exp_w) begin
                errors++;
                $display("FAIL ws_wdata c%0d got %h exp %h", c, Hwdata, exp_w);
            end
            checks++;
            if (Hreadyin !== rdy_v[c]) begin
                errors++;
                $display("FAIL ws_readyin c%0d got %b exp %b", c, Hreadyin, rdy_v[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        Hbusreq = 2'b10; Hreadyout = 1'b1;
        tr0 = 2'b00; tr1 = 2'b10; wd0 = 32'h0000_AAAA; wd1 = 32'h0000_BBBB;
        Hresetn = 1'b1;
        next_cycle();
        next_cycle();
        tr1 = 2'b11;
        next_cycle();
        checks++;
        if (Hmaster !== 2'd1 || Htrans !== 2'b11 || Hwdata !== wd1) begin
            errors++;
            $display("FAIL ar_pre got %0d/%b/%h exp 1/11/%h",
                     Hmaster, Htrans, Hwdata, wd1);
        end
        #2;
        Hresetn = 1'b0;
        #1;
        checks++;
        if (Hgrant !== 2'b01) begin
            errors++;
            $display("FAIL ar_grant got %b exp 01", Hgrant);
        end
        checks++;
        if (Hmaster !== 2'd0) begin
            errors++;
            $display("FAIL ar_master got %0d exp 0", Hmaster);
        end
        checks++;
        if (Htrans !== 2'b00) begin
            errors++;
            $display("FAIL ar_trans got %b exp 00", Htrans);
        end
        checks++;
        if (Hwdata !== wd0) begin
            errors++;
            $display("FAIL ar_wdata got %h exp %h", Hwdata, wd0);
        end
        #1;
        Hresetn = 1'b1;
        Hbusreq = 2'b00;
        next_cycle();
    endtask

    initial begin
        Hresetn = 1'b0;
        test_reset();
        test_grant();
        test_round_robin();
        test_handover_wdata();
        test_wait_states();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_bridge_arbiter.md
# ahb_bridge_arbiter

Round-robin arbiter that shares the single AHB slave port of the AHB-to-APB bridge between `NUM_MASTERS` AHB masters. It grants bus ownership through a `Hbusreq`/`Hgrant` handshake and multiplexes the granted master's address/control phase and the previous owner's write-data phase onto the bridge inputs. It broadcasts the bridge response back to all masters and enforces a per-owner transfer cap so no master can starve the others. It sits between the masters and the bridge's `Htrans`/`Haddr`/`Hwrite`/`Hsize`/`Hwdata`/`Hreadyin` inputs.

## Interface
- `NUM_MASTERS`, default 2: number of requesters, 2..4.
- `MAX_HOLD`, default 4: maximum transfers accepted from one owner while another master requests, ≥1.
- `Hclk`  in  1  clock.
- `Hresetn`  in  1  asynchronous, active-low reset.
- `Hbusreq`  in  NUM_MASTERS  per-master bus request.
- `Htrans_m`  in  2*NUM_MASTERS  per-master Htrans; master i uses bits [2i+1:2i].
- `Haddr_m`  in  32*NUM_MASTERS  per-master address.
- `Hwrite_m`  in  NUM_MASTERS  per-master write flag.
- `Hsize_m`  in  3*NUM_MASTERS  per-master size.
- `Hwdata_m`  in  32*NUM_MASTERS  per-master write data.
- `Hreadyout`  in  1  bridge ready.
- `Hgrant`  out  NUM_MASTERS  one-hot grant, registered.
- `Hmaster`  out  2  index of current address-phase owner, registered.
- `Htrans`, `Haddr`, `Hwrite`, `Hsize`  out  2/32/1/3  bridge address and control.
- `Hwdata`  out  32  bridge write data.
- `Hreadyin`  out  1  equals `Hreadyout`; also fanned out to all masters as their ready.

## Operation
- Three registers define ownership state:
  - `Hgrant`: the next owner.
  - `addr_owner`: drives `Hmaster` and the address/control mux.
  - `data_owner`: drives the `Hwdata` mux.
- Reset values:
  - `Hgrant` = one-hot bit 0.
  - `addr_owner` = `data_owner` = 0.
  - `hold_cnt` = 0.
  - Forwarded `Htrans` = IDLE (2'b00), because reset is forced onto the output mux.
- Ownership update on every `Hclk` edge with `Hreadyout`=1:
  - `addr_owner` ← index of `Hgrant`.
  - `data_owner` ← `addr_owner`.
- With `Hreadyout`=0, `Hgrant`, `addr_owner`, `data_owner` and `hold_cnt` all hold.
- Re-arbitration is evaluated only when `Hreadyout`=1. It triggers when either:
  - `Hbusreq[addr_owner]`=0, or
  - `hold_cnt`=`MAX_HOLD` and any other master requests.
- Winner selection:
  - The winner is the first requesting master scanning `addr_owner`+1, +2, … modulo `NUM_MASTERS`.
  - The current owner is considered last.
  - If no master requests, the grant parks on the current owner.
- `hold_cnt`:
  - Increments, saturating at `MAX_HOLD`, on each `Hreadyout`=1 edge where the forwarded `Htrans` is NONSEQ or SEQ.
  - Clears to 0 when `addr_owner` changes.
- Forced IDLE: the forwarded `Htrans` is IDLE whenever `Hgrant[addr_owner]`=0, i.e. during the handover cycle. A preempted burst is restarted by its master with NONSEQ.
- `Hwrite`, `Hsize` and `Haddr` always pass through from `addr_owner`.
- `Hwdata` always passes through from `data_owner`.
- Muxes are combinational.
- Out-of-range indices (when `NUM_MASTERS` < 4) select master 0.

## Timing
- From request to address ownership:
  - `Hbusreq` sampled at edge t with `Hreadyout`=1 produces `Hgrant` at edge t.
  - `Hmaster` and the address mux switch at the next `Hreadyout`=1 edge.
  - `Hwdata` switches one further `Hreadyout`=1 edge later.
- Minimum handover is 2 cycles, including 1 forced-IDLE address phase.
- Wait states stretch every stage equally. No state changes while `Hreadyout`=0.
- Asynchronous reset mid-transfer:
  - All registers return to reset values immediately.
  - `Htrans` goes IDLE in the same cycle, without waiting for an edge.
- Simultaneous events:
  - Owner deasserts `Hbusreq` in the same cycle `hold_cnt` saturates: a single re-arbitration occurs.
  - All masters request at once after reset: master 0 keeps the grant until `MAX_HOLD`, then round-robin order 1, 2, ….

## Test plan
- Assert then release reset with `Hbusreq`=0: `Hgrant`=01, `Hmaster`=0, `Htrans`=00 throughout.
- M1 requests with NONSEQ to 0x8000_0010 while M0 is idle, `Hreadyout`=1:
  - `Hgrant`=10 after 1 edge.
  - `Htrans`=IDLE for 1 cycle.
  - `Hmaster`=1 and `Haddr`=0x8000_0010 after the 2nd edge.
- M0 and M1 both request continuously with `MAX_HOLD`=4, each issuing back-to-back NONSEQ writes: `Hmaster` alternates after every 4 accepted transfers, with one IDLE cycle at each switch.
- Handover where M0 writes 0xA5A5_0001 as its last transfer: in the first M1 address cycle, `Haddr` comes from M1 while `Hwdata`=0xA5A5_0001 from M0.
- `Hreadyout` held low for 3 cycles during a pending handover: `Hgrant`, `Hmaster`, `Hwdata` source and `hold_cnt` stay frozen, then the handover completes on the first ready edge.
- Pulse `Hresetn` low while M1 owns the bus mid-burst: `Hgrant`=01, `Hmaster`=0 and `Htrans`=IDLE immediately, without a clock edge.
